// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
//   Shared types and constants for the data memory controller:
//     dmem_size_t   - access size codes (byte / half / word / reserved)
//     dmem_state_t  - controller FSM states (IDLE, WAIT, RESP)
//     dmem_req_t    - latched request fields
//     WCNT_W        - width of the wait-state counter
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int WCNT_W = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } dmem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic        write;
        dmem_size_t  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage : dmem_pkg

// File: rtl/dmem_lane_align.sv
// ---------------------------------------------------------------------------
// dmem_lane_align
//   Combinational little-endian lane steering for byte/half/word accesses.
//   Ports:
//     size_i      access size code
//     addr_lo_i   byte offset within the word (addr[1:0])
//     unsigned_i  loads: 1 = zero-extend, 0 = sign-extend
//     wdata_i     store data, narrow data in the low bits
//     rword_i     current contents of the addressed memory word
//     wmask_o     per-byte write enable
//     wword_o     store data replicated onto every candidate lane
//     rdata_o     selected and extended load data
//     misalign_o  halfword on odd address or word on non-zero offset
//   The reserved size code is not flagged here; the top treats it as a fault.
// ---------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  dmem_size_t  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Lane picks: byte lane k lives at bits [8k+7:8k], half lane at [16h+15:16h].
    assign rbyte = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign rhalf = rword_i[{addr_lo_i[1], 4'b0000} +: 16];

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        wmask_o    = 4'b0000;
        wword_o    = 32'h0;
        rdata_o    = 32'h0;
        misalign_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                wmask_o = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
                rdata_o = unsigned_i ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
            end
            SZ_HALF: begin
                misalign_o = addr_lo_i[0];
                wmask_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o    = {2{wdata_i[15:0]}};
                rdata_o    = unsigned_i ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
            end
            SZ_WORD: begin
                misalign_o = (addr_lo_i != 2'b00);
                wmask_o    = 4'b1111;
                wword_o    = wdata_i;
                rdata_o    = rword_i;
            end
            default: ;
        endcase
    end

endmodule : dmem_lane_align

// File: rtl/data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl
//   Word-organised data memory behind a valid/ready request port, with
//   byte/half/word accesses, programmable wait states, sign/zero-extended
//   loads and alignment/range/size faults.
//   Parameters:
//     DEPTH_WORDS  number of 32-bit words (power of 2, >= 4)
//     WAIT_CYCLES  extra cycles between accept and commit (0..15)
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     req_valid / req_ready    request handshake (ready only in IDLE)
//     req_write, req_size,
//     req_unsigned, req_addr,
//     req_wdata                request fields, latched on accept
//     rsp_valid                one-cycle completion pulse
//     rsp_rdata                extended load data, 0 on store or fault
//     rsp_fault                access faulted (no write performed)
//     fault_count              saturating count of faulting responses
//                              (only with DMEM_FAULT_CNT_EN defined)
//   The access commits on the clock edge that enters RESP. When that edge
//   comes straight from IDLE the live request fields are used, otherwise the
//   latched copy. The storage array has no reset.
// ---------------------------------------------------------------------------
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
`ifdef DMEM_FAULT_CNT_EN
    output logic        rsp_fault,
    output logic [15:0] fault_count
`else
    output logic        rsp_fault
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_t       state_q, state_d;
    logic [WCNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t         req_q;
    dmem_req_t         req_in;
    dmem_req_t         acc;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_fault_q;
    logic              commit;

    logic [31:0]       mem_q [DEPTH_WORDS] = '{default: 32'h0};
    logic [AW-1:0]     idx;
    logic [31:0]       rword;
    logic [3:0]        wmask;
    logic [31:0]       wword;
    logic [31:0]       ldata;
    logic              misalign;
    logic              out_of_range;
    logic              fault;

    assign req_in = '{write: req_write, size: dmem_size_t'(req_size),
                      uns: req_unsigned, addr: req_addr, wdata: req_wdata};

    // In IDLE the access may commit on this very edge, so use the live fields.
    assign acc          = (state_q == IDLE) ? req_in : req_q;
    assign idx          = acc.addr[AW+1:2];
    assign rword        = mem_q[idx];
    assign out_of_range = |acc.addr[31:AW+2];
    assign fault        = misalign || out_of_range || (acc.size == SZ_RSVD);

    dmem_lane_align u_align (
        .size_i     (acc.size),
        .addr_lo_i  (acc.addr[1:0]),
        .unsigned_i (acc.uns),
        .wdata_i    (acc.wdata),
        .rword_i    (rword),
        .wmask_o    (wmask),
        .wword_o    (wword),
        .rdata_o    (ldata),
        .misalign_o (misalign)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (fault || (WAIT_CYCLES == 0)) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WCNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - WCNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_rdata_q <= 32'h0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (commit) begin
                rsp_fault_q <= fault;
                rsp_rdata_q <= (fault || acc.write) ? 32'h0 : ldata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && req_valid) begin
            req_q <= req_in;
        end
    end

    // NOTE: the storage array is deliberately left out of reset; a reset
    // port on every word would prevent mapping it onto RAM. The rst gate
    // below only stops an aborted request from writing.
    always_ff @(posedge clk) begin
        if (!rst && commit && acc.write && !fault) begin
            for (int k = 0; k < 4; k++) begin
                if (wmask[k]) begin
                    mem_q[idx][8*k +: 8] <= wword[8*k +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;

`ifdef DMEM_FAULT_CNT_EN
    logic [15:0] fault_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_cnt_q <= 16'h0;
        end else if (rsp_valid && rsp_fault_q && (fault_cnt_q != 16'hFFFF)) begin
            fault_cnt_q <= fault_cnt_q + 16'h1;
        end
    end

    assign fault_count = fault_cnt_q;
`endif

endmodule : data_memory_ctrl

// File: tb/tb_data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_memory_ctrl
//   Directed bench for data_memory_ctrl (DEPTH_WORDS=256, WAIT_CYCLES=2).
//   Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_data_memory_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
`ifdef DMEM_FAULT_CNT_EN
    logic [15:0] fault_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
`ifdef DMEM_FAULT_CNT_EN
        .rsp_fault    (rsp_fault),
        .fault_count  (fault_count)
`else
        .rsp_fault    (rsp_fault)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait for its response. Returns the response
    // fields and the latency in cycles counted from the accept cycle.
    task automatic xact(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic f, output int lat);
        int n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        step();
        // Scramble the request while the block is busy; it must be ignored.
        req_valid    = 1'b0;
        req_write    = ~w;
        req_size     = ~sz;
        req_unsigned = ~u;
        req_addr     = ~a;
        req_wdata    = ~d;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
        rd = rsp_rdata;
        f  = rsp_fault;
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic        f;
        int          lat;
        xact(1'b1, sz, 1'b0, a, d, rd, f, lat);
    endtask

    logic [31:0] rd;
    logic        f;
    int          lat;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) step();
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_fault", 32'(rsp_fault), 32'd0);
        rst = 1'b0;
        step();

        // 1. word store / load with latency
        xact(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, rd, f, lat);
        check("t1_st_lat", 32'(lat), 32'd3);
        check("t1_st_fault", 32'(f), 32'd0);
        check("t1_st_rdata", rd, 32'h0);
        xact(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, f, lat);
        check("t1_ld_data", rd, 32'hDEADBEEF);
        check("t1_ld_fault", 32'(f), 32'd0);
        check("t1_ld_lat", 32'(lat), 32'd3);
        step();
        check("t1_pulse", 32'(rsp_valid), 32'd0);
        xact(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, rd, f, lat);
        check("t1_byte3_s", rd, 32'hFFFFFFDE);

        // 2. byte store into a word
        store(SZ_WORD, 32'h20, 32'h11223344);
        store(SZ_BYTE, 32'h21, 32'h123456AA);
        xact(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, rd, f, lat);
        check("t2_word", rd, 32'h1122AA44);
        xact(1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0, rd, f, lat);
        check("t2_byte_s", rd, 32'hFFFFFFAA);
        xact(1'b0, SZ_BYTE, 1'b1, 32'h21, 32'h0, rd, f, lat);
        check("t2_byte_u", rd, 32'h000000AA);
        xact(1'b0, SZ_BYTE, 1'b0, 32'h20, 32'h0, rd, f, lat);
        check("t2_byte0_s", rd, 32'h00000044);

        // 3. halfword store into upper lane
        store(SZ_HALF, 32'h22, 32'h55558001);
        xact(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, rd, f, lat);
        check("t3_word", rd, 32'h8001AA44);
        xact(1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, rd, f, lat);
        check("t3_half_s", rd, 32'hFFFF8001);
        xact(1'b0, SZ_HALF, 1'b1, 32'h20, 32'h0, rd, f, lat);
        check("t3_half_lo_u", rd, 32'h0000AA44);
        xact(1'b0, SZ_HALF, 1'b0, 32'h20, 32'h0, rd, f, lat);
        check("t3_half_lo_s", rd, 32'hFFFFAA44);

        // 4. faults
        xact(1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, rd, f, lat);
        check("t4_mis_fault", 32'(f), 32'd1);
        check("t4_mis_rdata", rd, 32'h0);
        check("t4_mis_lat", 32'(lat), 32'd1);
        store(SZ_WORD, 32'h24, 32'h0BADF00D);
        xact(1'b1, SZ_HALF, 1'b0, 32'h25, 32'h0000FFFF, rd, f, lat);
        check("t4_half_fault", 32'(f), 32'd1);
        xact(1'b0, SZ_WORD, 1'b0, 32'h24, 32'h0, rd, f, lat);
        check("t4_half_nowr", rd, 32'h0BADF00D);
        check("t4_good_fault", 32'(f), 32'd0);
        xact(1'b0, SZ_RSVD, 1'b0, 32'h10, 32'h0, rd, f, lat);
        check("t4_rsvd_fault", 32'(f), 32'd1);
        check("t4_rsvd_rdata", rd, 32'h0);
        xact(1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0, rd, f, lat);
        check("t4_range_fault", 32'(f), 32'd1);
        store(SZ_WORD, 32'h3FC, 32'hCAFEF00D);
        xact(1'b0, SZ_WORD, 1'b0, 32'h3FC, 32'h0, rd, f, lat);
        check("t4_last_data", rd, 32'hCAFEF00D);
        check("t4_last_fault", 32'(f), 32'd0);

        // 5. reset during WAIT aborts the store (early and on the commit edge)
        store(SZ_WORD, 32'h30, 32'h12345678);
        step();
        check("t5_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = 1'b1; req_size = SZ_WORD;
        req_unsigned = 1'b0; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF;
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_ready_after_rst", 32'(req_ready), 32'd1);
        check("t5_no_rsp", 32'(rsp_valid), 32'd0);
        repeat (3) begin
            step();
            check("t5_no_rsp_later", 32'(rsp_valid), 32'd0);
        end
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5b_no_rsp", 32'(rsp_valid), 32'd0);
        xact(1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, rd, f, lat);
        check("t5_word_kept", rd, 32'h12345678);

`ifdef DMEM_FAULT_CNT_EN
        // 6. fault counter
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_cnt_rst", 32'(fault_count), 32'd0);
        xact(1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, rd, f, lat);
        xact(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, f, lat);
        xact(1'b0, SZ_RSVD, 1'b0, 32'h10, 32'h0, rd, f, lat);
        xact(1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, rd, f, lat);
        xact(1'b1, SZ_HALF, 1'b0, 32'h401, 32'h0, rd, f, lat);
        step();
        check("t6_cnt3", 32'(fault_count), 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_cnt_clr", 32'(fault_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_data_memory_ctrl
